// File: rtl/coeff_pkg.sv
// coeff_pkg: shared coefficient types and FSM states for the coefficient loader and CoeffCollect
package coeff_pkg;
  localparam int NCOEF = 9;
  localparam int CW = 9;
  typedef logic signed [CW-1:0] coeff_t;
  typedef coeff_t coeff_set_t [NCOEF];
  typedef enum logic [1:0] {IDLE, FILL, DROP, PEND} state_t;
endpackage

// File: rtl/coeff_shadow_bank.sv
// coeff_shadow_bank: NCOEF x CW register file with indexed write, bulk read and synchronous clear
module coeff_shadow_bank #(
  parameter int NCOEF = coeff_pkg::NCOEF,
  parameter int CW = coeff_pkg::CW,
  localparam int AW = $clog2(NCOEF + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [CW-1:0] wdata,
  output logic signed [CW-1:0] rdata [NCOEF]
);
  logic signed [CW-1:0] mem_q [NCOEF];
  logic signed [CW-1:0] mem_d [NCOEF];
  always_comb begin
    mem_d = mem_q;
    if (clr) mem_d = '{default: '0};
    else if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign rdata = mem_q;
endmodule

// File: rtl/coeff_load_ctrl.sv
// coeff_load_ctrl: streams a coefficient set into a shadow bank and swaps it active at a frame boundary
module coeff_load_ctrl #(
  parameter int NCOEF = coeff_pkg::NCOEF,
  parameter int CW = coeff_pkg::CW,
  parameter int RST_CENTER = 64,
  localparam int LW = $clog2(NCOEF + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic signed [CW-1:0] cfg_data,
  input  logic                 cfg_last,
  input  logic                 swap_req,
  output logic signed [CW-1:0] coeffs_data [NCOEF],
  output logic                 coeffs_upd,
  output logic                 busy,
  output logic [LW-1:0]        load_cnt,
  output logic                 err_len,
  input  logic                 err_clr
);
  import coeff_pkg::*;
  localparam logic [LW-1:0] LAST = LW'(NCOEF - 1);
  state_t state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, upd_q, upd_d, acc, we, clr;
  logic signed [CW-1:0] act_q [NCOEF];
  logic signed [CW-1:0] act_d [NCOEF];
  logic signed [CW-1:0] shadow [NCOEF];
  coeff_shadow_bank #(.NCOEF(NCOEF), .CW(CW)) u_bank (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(cnt_q), .wdata(cfg_data), .rdata(shadow)
  );
  assign cfg_ready = state_q != PEND;
  assign busy = state_q != IDLE;
  assign acc = cfg_valid & cfg_ready;
  assign coeffs_data = act_q;
  assign coeffs_upd = upd_q;
  assign load_cnt = cnt_q;
  assign err_len = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q & ~err_clr;
    act_d = act_q;
    upd_d = 1'b0;
    we = 1'b0;
    clr = 1'b0;
    if (acc && (state_q == IDLE || state_q == FILL)) begin
      we = 1'b1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = cfg_last ? PEND : DROP;
        err_d = err_d | ~cfg_last;
      end else if (cfg_last) begin
        state_d = IDLE;
        cnt_d = '0;
        err_d = 1'b1;
      end else state_d = FILL;
    end
    // overlong sets are drained until their last beat; the count stays parked at NCOEF
    if (acc && state_q == DROP && cfg_last) begin
      state_d = IDLE;
      cnt_d = '0;
    end
    if (state_q == PEND && swap_req) begin
      act_d = shadow;
      upd_d = 1'b1;
      cnt_d = '0;
      clr = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
      upd_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) act_q[i] <= (i == NCOEF / 2) ? CW'(RST_CENTER) : '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      upd_q <= upd_d;
      act_q <= act_d;
    end
endmodule

// File: tb/tb_coeff_load_ctrl.sv
// tb_coeff_load_ctrl: directed self-checking bench for coeff_load_ctrl
module tb_coeff_load_ctrl;
  import coeff_pkg::*;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_last = 1'b0, swap_req = 1'b0, err_clr = 1'b0;
  coeff_t cfg_data = '0;
  logic cfg_ready, coeffs_upd, busy, err_len;
  coeff_set_t coeffs_data, exp_set, rst_set;
  logic [3:0] load_cnt;
  int checks = 0, errors = 0, upd_cnt = 0;
  coeff_load_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .swap_req(swap_req), .coeffs_data(coeffs_data), .coeffs_upd(coeffs_upd),
    .busy(busy), .load_cnt(load_cnt), .err_len(err_len), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (coeffs_upd === 1'b1) upd_cnt++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  function automatic logic [NCOEF*CW-1:0] pk(input coeff_set_t a);
    logic [NCOEF*CW-1:0] r;
    for (int i = 0; i < NCOEF; i++) r[i*CW +: CW] = a[i];
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input int d, input logic l);
    cfg_valid = 1'b1;
    cfg_data = coeff_t'(d);
    cfg_last = l;
    tick();
    cfg_valid = 1'b0;
    cfg_last = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    rst_set = '{default: '0};
    rst_set[NCOEF/2] = 9'sd64;
    checks++; if (pk(coeffs_data) !== pk(rst_set)) begin errors++; $display("FAIL reset_coeffs got %h exp %h", pk(coeffs_data), pk(rst_set)); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_len); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", load_cnt); end
    checks++; if (coeffs_upd !== 1'b0) begin errors++; $display("FAIL reset_upd got %b exp 0", coeffs_upd); end
  endtask
  task automatic test_normal_load();
    upd_cnt = 0;
    for (int k = 0; k < 9; k++) beat(k - 4, k == 8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy got %b exp 1", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL normal_ready got %b exp 0", cfg_ready); end
    checks++; if (load_cnt !== 4'd9) begin errors++; $display("FAIL normal_cnt got %0d exp 9", load_cnt); end
    checks++; if (pk(coeffs_data) !== pk(rst_set)) begin errors++; $display("FAIL normal_hold got %h exp %h", pk(coeffs_data), pk(rst_set)); end
    tick();
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int k = 0; k < 9; k++) exp_set[k] = coeff_t'(k - 4);
    checks++; if (pk(coeffs_data) !== pk(exp_set)) begin errors++; $display("FAIL normal_coeffs got %h exp %h", pk(coeffs_data), pk(exp_set)); end
    checks++; if (coeffs_upd !== 1'b1) begin errors++; $display("FAIL normal_upd got %b exp 1", coeffs_upd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_idle got %b exp 0", busy); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL normal_cnt0 got %0d exp 0", load_cnt); end
    tick();
    tick();
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL normal_pulses got %0d exp 1", upd_cnt); end
  endtask
  task automatic test_short_set();
    upd_cnt = 0;
    for (int k = 0; k < 5; k++) beat(10 + k, k == 4);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", err_len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_idle got %b exp 0", busy); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL short_cnt got %0d exp 0", load_cnt); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL short_ready got %b exp 1", cfg_ready); end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    checks++; if (pk(coeffs_data) !== pk(exp_set)) begin errors++; $display("FAIL short_coeffs got %h exp %h", pk(coeffs_data), pk(exp_set)); end
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL short_upd got %0d exp 0", upd_cnt); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL short_clr got %b exp 0", err_len); end
  endtask
  task automatic test_long_set();
    upd_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 8) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL long_ready%0d got %b exp 1", k, cfg_ready); end
      end
      beat(20 + k, k == 11);
      if (k == 7) begin
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL long_err7 got %b exp 0", err_len); end
      end
      if (k == 8) begin
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL long_err8 got %b exp 1", err_len); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL long_busy8 got %b exp 1", busy); end
      end
      if (k == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_idle got %b exp 0", busy); end
        checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL long_cnt got %0d exp 0", load_cnt); end
      end
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    checks++; if (pk(coeffs_data) !== pk(exp_set)) begin errors++; $display("FAIL long_coeffs got %h exp %h", pk(coeffs_data), pk(exp_set)); end
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL long_upd got %0d exp 0", upd_cnt); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask
  task automatic test_swap_timing();
    upd_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      swap_req = (k == 8);
      beat(30 + k, k == 8);
    end
    checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL coinc_pend got busy=%b ready=%b exp 1 0", busy, cfg_ready); end
    checks++; if (coeffs_upd !== 1'b0) begin errors++; $display("FAIL coinc_upd got %b exp 0", coeffs_upd); end
    checks++; if (pk(coeffs_data) !== pk(exp_set)) begin errors++; $display("FAIL coinc_hold got %h exp %h", pk(coeffs_data), pk(exp_set)); end
    tick();
    swap_req = 1'b0;
    for (int k = 0; k < 9; k++) exp_set[k] = coeff_t'(30 + k);
    checks++; if (pk(coeffs_data) !== pk(exp_set)) begin errors++; $display("FAIL late_coeffs got %h exp %h", pk(coeffs_data), pk(exp_set)); end
    checks++; if (coeffs_upd !== 1'b1) begin errors++; $display("FAIL late_upd got %b exp 1", coeffs_upd); end
    tick();
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL late_pulses got %0d exp 1", upd_cnt); end
    upd_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      repeat ($urandom_range(0, 2)) begin
        swap_req = 1'b1;
        tick();
      end
      swap_req = (k != 8);
      beat(40 + k, k == 8);
    end
    swap_req = 1'b0;
    checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL gaps_pend got busy=%b ready=%b exp 1 0", busy, cfg_ready); end
    checks++; if (pk(coeffs_data) !== pk(exp_set)) begin errors++; $display("FAIL gaps_hold got %h exp %h", pk(coeffs_data), pk(exp_set)); end
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL gaps_upd got %0d exp 0", upd_cnt); end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int k = 0; k < 9; k++) exp_set[k] = coeff_t'(40 + k);
    checks++; if (pk(coeffs_data) !== pk(exp_set)) begin errors++; $display("FAIL gaps_coeffs got %h exp %h", pk(coeffs_data), pk(exp_set)); end
  endtask
  task automatic test_reset_pend_err();
    for (int k = 0; k < 9; k++) beat(50 + k, k == 8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rpend_busy got %b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pk(coeffs_data) !== pk(rst_set)) begin errors++; $display("FAIL rpend_coeffs got %h exp %h", pk(coeffs_data), pk(rst_set)); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL rpend_idle got busy=%b ready=%b exp 0 1", busy, cfg_ready); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL rpend_cnt got %0d exp 0", load_cnt); end
    tick();
    rst = 1'b0;
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++; if (pk(coeffs_data) !== pk(rst_set)) begin errors++; $display("FAIL rpend_lost got %h exp %h", pk(coeffs_data), pk(rst_set)); end
    beat(60, 1'b0);
    err_clr = 1'b1;
    beat(61, 1'b1);
    err_clr = 1'b0;
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL errclr_setwins got %b exp 1", err_len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL errclr_idle got %b exp 0", busy); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL errclr_clear got %b exp 0", err_len); end
  endtask
  initial begin
    test_reset();
    test_normal_load();
    test_short_set();
    test_long_set();
    test_swap_timing();
    test_reset_pend_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
